decode_lanes: RTL
=================

DECODE_LANES -- requirements
Module: decode_lanes

Interface
REQ-001 SHALL have parameter LANES, default 2, range 1-4, instruction slots per bundle.
REQ-002 SHALL have parameter LINK_REG, default 31, link register index.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gpr  gpr_if  32x32  register-file read view.
REQ-006 SHALL have port in_valid  input  1  bundle offered.
REQ-007 SHALL have port in_ready  output  1  bundle accepted when in_valid&&in_ready.
REQ-008 SHALL have port in_pc  input  32  bundle PC.
REQ-009 SHALL have port in_inst  input  32*LANES  lane 0 in bits [32*LANES-1 -: 32], lane k below lane k-1.
REQ-010 SHALL have port out_valid  input-side-paired output  1  registered bundle valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have ports out_pc 32, out_inst 32*LANES, out_srca/out_srcb/out_srcs 32*LANES, out_e_type 4*LANES, out_rt 5*LANES, out_rt_flag LANES, all outputs, per-lane packed like in_inst.
REQ-013 SHALL have ports mem_addr 32*LANES, mem_din 32*LANES, mem_we 4*LANES, outputs.
REQ-014 SHALL have ports branch_flag 1, branch_pc 32, halted 1, outputs.

Function
REQ-015 in_ready SHALL equal (~out_valid | out_ready) & ~branch_flag & ~halted, combinational.
REQ-016 On accept, all out_* SHALL load in one cycle (latency 1); with out_valid&&~out_ready they SHALL hold.
REQ-017 With no accept and out consumed (or empty), out_valid SHALL go 0 and out_rt_flag, mem_we SHALL be 0.
REQ-018 Per lane: srca=gpr[rA], srcs=gpr[rS], mem_addr=gpr[rA]+si, mem_din=gpr[rS], mem_we=4'b1111 iff Store; si = sign-extended low 16 bits, li = zero-extended low 26 bits.
REQ-019 srcb SHALL be gpr[rB] for Add Sub Xor And Fadd Fsub Fmul Fdiv Fsqrt Ftoi Itof, pc+1 for Bl/Blrr, lane-1 word for Liw (LANES>=2), else si.
REQ-020 e_type SHALL map Addi/Add->EAdd, Subi/Sub->ESub, Srawi->ERshift, Slawi->ELshift, Xor->EXor, And->EAnd, F-ops/Ftoi/Itof to matching E-code, else ENop.
REQ-021 rt SHALL be LINK_REG for Bl/Blrr, else bits [25:21]; rt_flag=1 for Addi Subi Add Sub Srawi Slawi Xor And Li Liw Bl Blrr, 0 otherwise (Load included).
REQ-022 Control opcodes (Liw Jump Blr Bl Blrr Beq Ble Blt Bne Bge Bgt) SHALL be decoded only in lane 0; when lane 0 holds any, lanes 1..LANES-1 SHALL be emitted as Nop with rt_flag 0, mem_we 0.
REQ-023 Internal flags eq/less SHALL update on accept from the lowest-index lane holding Cmpd (signed), Cmpdi (vs si) or Cmpf (eq also if both exponents [30:23] zero; less from fless); no compare -> unchanged.
REQ-024 Conditional branches SHALL use eq/less as registered before the accepting edge: Beq eq, Bne ~eq, Blt less, Bge ~less, Ble eq|less, Bgt ~(eq|less).
REQ-025 On accept of a taken control op, branch_flag SHALL be 1 for exactly the next cycle with branch_pc = li (Jump Bl, taken cond), gpr[LINK_REG] (Blr), gpr[rS] (Blrr); otherwise branch_flag 0, branch_pc 0.
REQ-026 While branch_flag=1 no bundle SHALL be accepted; eq/less SHALL clear to 0 that cycle.
REQ-027 On accept of End in lane 0, halted SHALL set and stay 1 until reset; End bundle itself is emitted.
REQ-028 LANES=1: Liw SHALL take srcb=si; no squash needed.

Reset
REQ-029 rstn low SHALL immediately clear out_valid, out_rt_flag, mem_we, branch_flag, branch_pc, eq, less, halted, out_pc to 0, out_inst to Nop in every lane, other data outputs 0; mid-stall or mid-branch state SHALL be discarded.

Verification
REQ-030 LANES=2, Add r3,r1,r2 / Addi r4,r1,5 with r1=7,r2=2 -> next cycle srca=7,7; srcb=2,5; e_type EAdd,EAdd; rt_flag 2'b11.
REQ-031 Cmpdi r1,7 bundle then Beq 0x40 -> branch_flag 1 one cycle, branch_pc 0x40, in_ready 0 that cycle, lane 1 Nop.
REQ-032 Bl 0x100 at pc 0x20 -> srcb 0x21, rt 31, rt_flag 1, branch_pc 0x100.
REQ-033 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready 0, no bundle lost after release.
REQ-034 LANES=4 Cmpd in lanes 1 and 3 -> flags from lane 1.
REQ-035 End accepted then rstn pulse mid-stall -> halted 1, then all outputs to reset values asynchronously.

Source files
------------

// File: rtl/decode_lanes_if.sv
// Register-file read view shared between the decoder and whatever owns the GPRs.
interface gpr_if;
  logic [31:0] regs [32];

  modport reader (input regs);
  modport owner  (output regs);
endinterface

// File: rtl/decode_lanes.sv
// decode_lanes: multi-lane instruction decoder with operand fetch, compare flags,
// lane-0 control-flow resolution and a one-entry registered output stage.
// Encoding: op [31:26], rt/rS [25:21], rA [20:16], rB [15:11], imm [15:0], li [25:0].
module decode_lanes #(
  parameter int LANES    = 2,
  parameter int LINK_REG = 31
) (
  input  logic                 clk,
  input  logic                 rstn,
  gpr_if.reader                gpr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [32*LANES-1:0]  in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [32*LANES-1:0]  out_inst,
  output logic [32*LANES-1:0]  out_srca,
  output logic [32*LANES-1:0]  out_srcb,
  output logic [32*LANES-1:0]  out_srcs,
  output logic [4*LANES-1:0]   out_e_type,
  output logic [5*LANES-1:0]   out_rt,
  output logic [LANES-1:0]     out_rt_flag,
  output logic [32*LANES-1:0]  mem_addr,
  output logic [32*LANES-1:0]  mem_din,
  output logic [4*LANES-1:0]   mem_we,
  output logic                 branch_flag,
  output logic [31:0]          branch_pc,
  output logic                 halted
);

  localparam logic [5:0] OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_XOR = 6'd3,  OP_AND = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5, OP_SUBI = 6'd6, OP_SRAWI = 6'd7, OP_SLAWI = 6'd8;
  localparam logic [5:0] OP_LI = 6'd9,   OP_LIW = 6'd10, OP_STORE = 6'd12;
  localparam logic [5:0] OP_CMPD = 6'd13, OP_CMPDI = 6'd14, OP_CMPF = 6'd15;
  localparam logic [5:0] OP_FADD = 6'd16, OP_FSUB = 6'd17, OP_FMUL = 6'd18, OP_FDIV = 6'd19;
  localparam logic [5:0] OP_FSQRT = 6'd20, OP_FTOI = 6'd21, OP_ITOF = 6'd22;
  localparam logic [5:0] OP_JUMP = 6'd23, OP_BLR = 6'd24, OP_BL = 6'd25, OP_BLRR = 6'd26;
  localparam logic [5:0] OP_BEQ = 6'd27, OP_BLE = 6'd28, OP_BLT = 6'd29, OP_BNE = 6'd30;
  localparam logic [5:0] OP_BGE = 6'd31, OP_BGT = 6'd32, OP_END = 6'd33;

  localparam logic [3:0] E_NOP = 4'd0, E_ADD = 4'd1, E_SUB = 4'd2, E_RSHIFT = 4'd3;
  localparam logic [3:0] E_LSHIFT = 4'd4, E_XOR = 4'd5, E_AND = 4'd6, E_FADD = 4'd7;
  localparam logic [3:0] E_FSUB = 4'd8, E_FMUL = 4'd9, E_FDIV = 4'd10, E_FSQRT = 4'd11;
  localparam logic [3:0] E_FTOI = 4'd12, E_ITOF = 4'd13;

  localparam logic [31:0] NOP_WORD = 32'd0;
  localparam logic [4:0]  LINK_IDX = 5'(LINK_REG);
  // Lane-1 word position; for a single lane it aliases lane 0 and is never selected.
  localparam int          L1_HI    = (LANES >= 2) ? 32*(LANES-1)-1 : 31;

  // Opcodes that only lane 0 may carry; their presence squashes the other lanes.
  function automatic logic is_ctrl(input logic [5:0] op);
    case (op)
      OP_LIW, OP_JUMP, OP_BLR, OP_BL, OP_BLRR,
      OP_BEQ, OP_BLE, OP_BLT, OP_BNE, OP_BGE, OP_BGT: is_ctrl = 1'b1;
      default:                                         is_ctrl = 1'b0;
    endcase
  endfunction

  // IEEE-754 single less-than on raw bits; +0 and -0 compare equal.
  function automatic logic f_less(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) f_less = a[31] && ((a[30:0] | b[30:0]) != 31'd0);
    else if (!a[31])    f_less = a[30:0] < b[30:0];
    else                f_less = a[30:0] > b[30:0];
  endfunction

  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_pc_q, out_pc_d;
  logic [32*LANES-1:0]  out_inst_q, out_inst_d, out_srca_q, out_srca_d;
  logic [32*LANES-1:0]  out_srcb_q, out_srcb_d, out_srcs_q, out_srcs_d;
  logic [32*LANES-1:0]  mem_addr_q, mem_addr_d, mem_din_q, mem_din_d;
  logic [4*LANES-1:0]   e_type_q, e_type_d, mem_we_q, mem_we_d;
  logic [5*LANES-1:0]   rt_q, rt_d;
  logic [LANES-1:0]     rt_flag_q, rt_flag_d;
  logic                 branch_flag_q, branch_flag_d, halted_q, halted_d;
  logic [31:0]          branch_pc_q, branch_pc_d;
  logic                 eq_q, eq_d, less_q, less_d;

  logic                 in_ready_s, accept_s, squash_s, take_s;
  logic [31:0]          w0_s, l1_word_s, target_s;
  logic [32*LANES-1:0]  dec_inst_s, dec_srca_s, dec_srcb_s, dec_srcs_s, dec_addr_s, dec_din_s;
  logic [4*LANES-1:0]   dec_e_type_s, dec_we_s;
  logic [5*LANES-1:0]   dec_rt_s;
  logic [LANES-1:0]     dec_rt_flag_s;
  logic                 cmp_hit_s, cmp_eq_s, cmp_less_s;

  // Handshake and lane-0 classification of the offered bundle.
  always_comb begin
    in_ready_s = (~out_valid_q | out_ready) & ~branch_flag_q & ~halted_q;
    accept_s   = in_valid & in_ready_s;
    w0_s       = in_inst[32*LANES-1 -: 32];
    squash_s   = is_ctrl(w0_s[31:26]);
    l1_word_s  = in_inst[L1_HI -: 32];
  end

  // Lane-0 branch resolution against the flags registered before this edge.
  always_comb begin
    take_s   = 1'b0;
    target_s = {6'd0, w0_s[25:0]};
    case (w0_s[31:26])
      OP_JUMP, OP_BL: take_s = 1'b1;
      OP_BLR:  begin take_s = 1'b1; target_s = gpr.regs[LINK_IDX]; end
      OP_BLRR: begin take_s = 1'b1; target_s = gpr.regs[w0_s[25:21]]; end
      OP_BEQ:  take_s = eq_q;
      OP_BNE:  take_s = ~eq_q;
      OP_BLT:  take_s = less_q;
      OP_BGE:  take_s = ~less_q;
      OP_BLE:  take_s = eq_q | less_q;
      OP_BGT:  take_s = ~(eq_q | less_q);
      default: take_s = 1'b0;
    endcase
  end

  // Per-lane decode, operand fetch and lowest-lane compare selection.
  always_comb begin : lane_decode
    logic [31:0] w, va, vb, vs, si;
    logic [5:0]  op;
    dec_inst_s = '0; dec_srca_s = '0; dec_srcb_s = '0; dec_srcs_s = '0;
    dec_addr_s = '0; dec_din_s = '0; dec_e_type_s = '0; dec_we_s = '0;
    dec_rt_s = '0; dec_rt_flag_s = '0;
    cmp_hit_s = 1'b0; cmp_eq_s = 1'b0; cmp_less_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      w  = in_inst[32*(LANES-k)-1 -: 32];
      w  = ((k != 0) && (squash_s || is_ctrl(w[31:26]))) ? NOP_WORD : w;
      op = w[31:26];
      va = gpr.regs[w[20:16]];
      vb = gpr.regs[w[15:11]];
      vs = gpr.regs[w[25:21]];
      si = {{16{w[15]}}, w[15:0]};
      dec_inst_s[32*(LANES-k)-1 -: 32] = w;
      dec_srca_s[32*(LANES-k)-1 -: 32] = va;
      dec_srcs_s[32*(LANES-k)-1 -: 32] = vs;
      dec_addr_s[32*(LANES-k)-1 -: 32] = va + si;
      dec_din_s[32*(LANES-k)-1 -: 32]  = vs;
      dec_we_s[4*(LANES-k)-1 -: 4]     = (op == OP_STORE) ? 4'b1111 : 4'b0000;
      dec_rt_s[5*(LANES-k)-1 -: 5]     = ((op == OP_BL) || (op == OP_BLRR)) ? LINK_IDX : w[25:21];
      case (op)
        OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_FADD, OP_FSUB, OP_FMUL,
        OP_FDIV, OP_FSQRT, OP_FTOI, OP_ITOF: dec_srcb_s[32*(LANES-k)-1 -: 32] = vb;
        OP_BL, OP_BLRR: dec_srcb_s[32*(LANES-k)-1 -: 32] = in_pc + 32'd1;
        OP_LIW:  dec_srcb_s[32*(LANES-k)-1 -: 32] = (LANES >= 2) ? l1_word_s : si;
        default: dec_srcb_s[32*(LANES-k)-1 -: 32] = si;
      endcase
      case (op)
        OP_ADDI, OP_ADD:   dec_e_type_s[4*(LANES-k)-1 -: 4] = E_ADD;
        OP_SUBI, OP_SUB:   dec_e_type_s[4*(LANES-k)-1 -: 4] = E_SUB;
        OP_SRAWI:          dec_e_type_s[4*(LANES-k)-1 -: 4] = E_RSHIFT;
        OP_SLAWI:          dec_e_type_s[4*(LANES-k)-1 -: 4] = E_LSHIFT;
        OP_XOR:            dec_e_type_s[4*(LANES-k)-1 -: 4] = E_XOR;
        OP_AND:            dec_e_type_s[4*(LANES-k)-1 -: 4] = E_AND;
        OP_FADD:           dec_e_type_s[4*(LANES-k)-1 -: 4] = E_FADD;
        OP_FSUB:           dec_e_type_s[4*(LANES-k)-1 -: 4] = E_FSUB;
        OP_FMUL:           dec_e_type_s[4*(LANES-k)-1 -: 4] = E_FMUL;
        OP_FDIV:           dec_e_type_s[4*(LANES-k)-1 -: 4] = E_FDIV;
        OP_FSQRT:          dec_e_type_s[4*(LANES-k)-1 -: 4] = E_FSQRT;
        OP_FTOI:           dec_e_type_s[4*(LANES-k)-1 -: 4] = E_FTOI;
        OP_ITOF:           dec_e_type_s[4*(LANES-k)-1 -: 4] = E_ITOF;
        default:           dec_e_type_s[4*(LANES-k)-1 -: 4] = E_NOP;
      endcase
      case (op)
        OP_ADDI, OP_SUBI, OP_ADD, OP_SUB, OP_SRAWI, OP_SLAWI, OP_XOR,
        OP_AND, OP_LI, OP_LIW, OP_BL, OP_BLRR: dec_rt_flag_s[LANES-1-k] = 1'b1;
        default:                               dec_rt_flag_s[LANES-1-k] = 1'b0;
      endcase
      // The first compare found (lowest lane index) owns the flags.
      if (!cmp_hit_s) begin
        case (op)
          OP_CMPD:  begin cmp_hit_s = 1'b1; cmp_eq_s = (va == vb);
                          cmp_less_s = ($signed(va) < $signed(vb)); end
          OP_CMPDI: begin cmp_hit_s = 1'b1; cmp_eq_s = (va == si);
                          cmp_less_s = ($signed(va) < $signed(si)); end
          OP_CMPF:  begin cmp_hit_s = 1'b1;
                          cmp_eq_s = (va == vb) || ((va[30:23] == 8'd0) && (vb[30:23] == 8'd0));
                          cmp_less_s = f_less(va, vb); end
          default:  cmp_hit_s = 1'b0;
        endcase
      end else begin
        cmp_hit_s = 1'b1;
      end
    end
  end

  // Next-state for the output stage, branch pulse, halt latch and compare flags.
  always_comb begin
    out_valid_d = out_valid_q; out_pc_d = out_pc_q; out_inst_d = out_inst_q;
    out_srca_d = out_srca_q; out_srcb_d = out_srcb_q; out_srcs_d = out_srcs_q;
    mem_addr_d = mem_addr_q; mem_din_d = mem_din_q; mem_we_d = mem_we_q;
    e_type_d = e_type_q; rt_d = rt_q; rt_flag_d = rt_flag_q;
    branch_flag_d = 1'b0; branch_pc_d = 32'd0; halted_d = halted_q;
    if (accept_s) begin
      out_valid_d = 1'b1; out_pc_d = in_pc; out_inst_d = dec_inst_s;
      out_srca_d = dec_srca_s; out_srcb_d = dec_srcb_s; out_srcs_d = dec_srcs_s;
      mem_addr_d = dec_addr_s; mem_din_d = dec_din_s; mem_we_d = dec_we_s;
      e_type_d = dec_e_type_s; rt_d = dec_rt_s; rt_flag_d = dec_rt_flag_s;
      branch_flag_d = take_s;
      branch_pc_d   = take_s ? target_s : 32'd0;
      halted_d      = halted_q | (w0_s[31:26] == OP_END);
    end else if (~out_valid_q | out_ready) begin
      out_valid_d = 1'b0; rt_flag_d = '0; mem_we_d = '0;
    end else begin
      out_valid_d = 1'b1;
    end
    if (branch_flag_q) begin
      eq_d = 1'b0; less_d = 1'b0;
    end else if (accept_s && cmp_hit_s) begin
      eq_d = cmp_eq_s; less_d = cmp_less_s;
    end else begin
      eq_d = eq_q; less_d = less_q;
    end
  end

  // State registers; reset discards any stalled bundle or pending branch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0; out_pc_q <= 32'd0; out_inst_q <= {LANES{NOP_WORD}};
      out_srca_q <= '0; out_srcb_q <= '0; out_srcs_q <= '0;
      mem_addr_q <= '0; mem_din_q <= '0; mem_we_q <= '0;
      e_type_q <= '0; rt_q <= '0; rt_flag_q <= '0;
      branch_flag_q <= 1'b0; branch_pc_q <= 32'd0; halted_q <= 1'b0;
      eq_q <= 1'b0; less_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d; out_pc_q <= out_pc_d; out_inst_q <= out_inst_d;
      out_srca_q <= out_srca_d; out_srcb_q <= out_srcb_d; out_srcs_q <= out_srcs_d;
      mem_addr_q <= mem_addr_d; mem_din_q <= mem_din_d; mem_we_q <= mem_we_d;
      e_type_q <= e_type_d; rt_q <= rt_d; rt_flag_q <= rt_flag_d;
      branch_flag_q <= branch_flag_d; branch_pc_q <= branch_pc_d; halted_q <= halted_d;
      eq_q <= eq_d; less_q <= less_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_inst    = out_inst_q;
  assign out_srca    = out_srca_q;
  assign out_srcb    = out_srcb_q;
  assign out_srcs    = out_srcs_q;
  assign out_e_type  = e_type_q;
  assign out_rt      = rt_q;
  assign out_rt_flag = rt_flag_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign branch_flag = branch_flag_q;
  assign branch_pc   = branch_pc_q;
  assign halted      = halted_q;

endmodule
